// File: rtl/counter_pkg.sv
// Shared definitions for the bounded up/down counter family: boundary modes and
// a binary-to-Gray helper sized for the widest supported counter.
package counter_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Callers narrower than MAX_WIDTH zero-extend in and truncate out.
    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_reg.sv
// Registers the Gray-coded copy of the counter from its next-state binary value,
// so the Gray output changes on the same edge as the binary count.
module gray_reg
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_next,
    output logic [WIDTH-1:0] gray
);

    logic [WIDTH-1:0] gray_next;

    assign gray_next = WIDTH'(bin2gray(MAX_WIDTH'(bin_next)));

    always_ff @(posedge clk) begin
        if (rst) begin
            gray <= '0;
        end else begin
            gray <= gray_next;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// WIDTH-bit modulo-MODULUS up/down counter with load, wrap/saturate boundary
// handling, a registered terminal-count pulse, sticky overflow and Gray output.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] z_gray,
    output logic             tc,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH + 1;

    generate
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("mod_updown_counter: WIDTH must be in 2..16");
        end
        if (MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_modulus
            $error("mod_updown_counter: MODULUS must be in 2..2^WIDTH");
        end
    endgenerate

    logic [CW-1:0]    z_ext;
    logic [CW-1:0]    top_val;
    logic [WIDTH-1:0] z_next;
    logic             boundary;

    assign z_ext   = {1'b0, z};
    assign top_val = CW'(MODULUS - 1);

    // Next-state mux: load beats count; boundary handling depends on sat.
    always_comb begin
        z_next   = z;
        boundary = 1'b0;
        if (load) begin
            if ({1'b0, din} < CW'(MODULUS)) begin
                z_next = din;
            end else begin
                z_next = WIDTH'(top_val);
            end
        end else if (x) begin
            boundary = up ? (z_ext == top_val) : (z_ext == '0);
            if (boundary) begin
                if (sat == MODE_WRAP) begin
                    z_next = up ? '0 : WIDTH'(top_val);
                end
            end else if (up) begin
                z_next = WIDTH'(z_ext + CW'(1));
            end else begin
                z_next = WIDTH'(z_ext - CW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            z   <= z_next;
            tc  <= boundary;
            ovf <= boundary | (ovf & ~clr_ovf);
        end
    end

    gray_reg #(
        .WIDTH(WIDTH)
    ) u_gray_reg (
        .clk     (clk),
        .rst     (rst),
        .bin_next(z_next),
        .gray    (z_gray)
    );

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed self-checking bench for mod_updown_counter at WIDTH=4, MODULUS=10.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       x;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic       sat;
    logic       clr_ovf;
    logic [3:0] z;
    logic [3:0] z_gray;
    logic       tc;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    mod_updown_counter #(
        .WIDTH  (4),
        .MODULUS(10)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .up     (up),
        .load   (load),
        .din    (din),
        .sat    (sat),
        .clr_ovf(clr_ovf),
        .z      (z),
        .z_gray (z_gray),
        .tc     (tc),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ez, input logic [3:0] eg,
                           input logic etc, input logic eovf);
        chk({tag, ".z"}, 16'(z), 16'(ez));
        chk({tag, ".z_gray"}, 16'(z_gray), 16'(eg));
        chk({tag, ".tc"}, 16'(tc), 16'(etc));
        chk({tag, ".ovf"}, 16'(ovf), 16'(eovf));
    endtask

    // Hand-written Gray codes for counts 0..9.
    logic [3:0] gray_tab [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                  4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};

    initial begin
        rst = 1'b1; x = 1'b0; up = 1'b0; load = 1'b0; din = 4'd0; sat = 1'b0; clr_ovf = 1'b0;
        tick();
        chk_all("reset", 4'd0, 4'd0, 1'b0, 1'b0);

        // Wrap up through 1..9 then roll to 0
        rst = 1'b0; x = 1'b1; up = 1'b1; sat = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk_all($sformatf("wrap_up_%0d", i), 4'(i), gray_tab[i], 1'b0, 1'b0);
        end
        tick();
        chk_all("wrap_up_roll", 4'd0, 4'd0, 1'b1, 1'b1);
        tick();
        chk_all("wrap_up_after", 4'd1, 4'd1, 1'b0, 1'b1);

        // Wrap down from 0
        rst = 1'b1; x = 1'b0;
        tick();
        chk_all("rst2", 4'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0; x = 1'b1; up = 1'b0;
        tick();
        chk_all("wrap_down_roll", 4'd9, 4'b1101, 1'b1, 1'b1);
        tick();
        chk_all("wrap_down_8", 4'd8, 4'b1100, 1'b0, 1'b1);

        // Saturate from 7
        rst = 1'b1; x = 1'b0;
        tick();
        rst = 1'b0; load = 1'b1; din = 4'd7;
        tick();
        chk_all("sat_load7", 4'd7, 4'b0100, 1'b0, 1'b0);
        load = 1'b0; x = 1'b1; up = 1'b1; sat = 1'b1;
        tick(); chk_all("sat_8", 4'd8, 4'b1100, 1'b0, 1'b0);
        tick(); chk_all("sat_9", 4'd9, 4'b1101, 1'b0, 1'b0);
        tick(); chk_all("sat_hold1", 4'd9, 4'b1101, 1'b1, 1'b1);
        tick(); chk_all("sat_hold2", 4'd9, 4'b1101, 1'b1, 1'b1);

        // Load clamp and priority
        sat = 1'b0; x = 1'b0; load = 1'b1; din = 4'd12;
        tick(); chk_all("load_clamp", 4'd9, 4'b1101, 1'b0, 1'b1);
        din = 4'd3; x = 1'b1;
        tick(); chk_all("load_beats_x", 4'd3, 4'b0010, 1'b0, 1'b1);
        din = 4'd0; up = 1'b0;
        tick(); chk_all("load0_down", 4'd0, 4'd0, 1'b0, 1'b1);
        load = 1'b0; x = 1'b0;
        tick(); chk_all("hold", 4'd0, 4'd0, 1'b0, 1'b1);

        // ovf set beats clear; then clear alone
        x = 1'b1; up = 1'b0; clr_ovf = 1'b1;
        tick(); chk_all("set_beats_clr", 4'd9, 4'b1101, 1'b1, 1'b1);
        x = 1'b0;
        tick(); chk_all("clr_only", 4'd9, 4'b1101, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        // Reset mid-count with load asserted
        x = 1'b1; up = 1'b1;
        tick(); chk_all("roll_again", 4'd0, 4'd0, 1'b1, 1'b1);
        x = 1'b0; load = 1'b1; din = 4'd6;
        tick(); chk_all("load6", 4'd6, 4'b0101, 1'b0, 1'b1);
        rst = 1'b1; x = 1'b1;
        tick(); chk_all("rst_mid", 4'd0, 4'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
